// File: rtl/uart_frame_decoder_pkg.sv
// uart_frame_pkg
//   Shared types and widths for the UART frame decoder.
//   state_t    : decoder FSM states
//   err_code_t : error code reported alongside a frame_err pulse
//   CNT_W      : payload byte counter width (LEN up to 15)
//   SUM_W      : running checksum width (8-bit wrap)
package uart_frame_pkg;

  localparam int CNT_W = 4;
  localparam int SUM_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CSUM    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// uart_frame_decoder_if
//   Byte-stream input and frame valid/ready output of the frame decoder.
//   rx_update   : one-cycle strobe, rx_data holds a new byte
//   rx_data     : received byte
//   frame_valid : verified frame available
//   frame_ready : consumer accepts when frame_valid & frame_ready
//   frame_data  : payload, first byte in [7:0]
//   frame_err   : one-cycle error pulse
//   err_code    : last error code
//   modport master : decoder side
//   modport slave  : byte source / frame consumer side
interface uart_frame_decoder_if
  import uart_frame_pkg::*;
#(
  parameter int LEN = 4
);

  logic             rx_update;
  logic [7:0]       rx_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [LEN*8-1:0] frame_data;
  logic             frame_err;
  err_code_t        err_code;

  modport master (
    input  rx_update,
    input  rx_data,
    input  frame_ready,
    output frame_valid,
    output frame_data,
    output frame_err,
    output err_code
  );

  modport slave (
    output rx_update,
    output rx_data,
    output frame_ready,
    input  frame_valid,
    input  frame_data,
    input  frame_err,
    input  err_code
  );

endinterface

// File: rtl/uart_frame_decoder_idle_timer.sv
// frame_idle_timer
//   Inter-byte idle counter with terminal-count compare.
//   clk, reset_n : clock, async active-low reset
//   clear        : force counter to 0 (new byte, or decoder not inside a frame)
//   enable       : count idle clocks
//   expire       : counter has reached TIMEOUT-1 while enabled
module frame_idle_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  assign expire = enable && (cnt == W'(TIMEOUT - 1));

  // Saturates at the terminal count so a stalled FSM cannot wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
//   Hunts for SYNC in the received byte stream, collects LEN payload bytes
//   and a checksum byte, and presents verified frames on a valid/ready port.
//   Checksum, overrun and (optional) inter-byte timeout errors produce a
//   one-cycle frame_err pulse with err_code.
//   Ports:
//     clk     : clock
//     reset_n : asynchronous active-low reset
//     bus     : uart_frame_decoder_if.master (rx byte input, frame output)
//   Build option:
//     FRAME_TIMEOUT_EN : enables the inter-byte idle timeout (TIMEOUT clocks)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for SYNC, other bytes dropped
//   PAYLOAD | storing payload byte cnt, accumulating sum
//   CSUM    | next byte is the checksum; sum+byte must be 0
//   HOLD    | verified frame presented, waiting for frame_ready
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         LEN     = 4,
  parameter int         TIMEOUT = 100000
) (
  input logic                  clk,
  input logic                  reset_n,
  uart_frame_decoder_if.master bus
);

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum;
    logic [LEN*8-1:0] data;
    logic             valid;
    logic             err;
    err_code_t        code;
  } regs_t;

  regs_t            cur;
  regs_t            nxt;
  logic [SUM_W-1:0] csum_total;
  logic             in_frame;
  logic             tmr_expire;

  assign csum_total = cur.sum + bus.rx_data;
  assign in_frame   = (cur.state == PAYLOAD) || (cur.state == CSUM);

`ifdef FRAME_TIMEOUT_EN
  frame_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.rx_update || !in_frame),
    .enable  (in_frame),
    .expire  (tmr_expire)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (|TIMEOUT) & in_frame;
  assign tmr_expire     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur <= '0;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt     = cur;
    nxt.err = 1'b0;
    case (cur.state)
      IDLE: begin
        if (bus.rx_update && (bus.rx_data == SYNC)) begin
          nxt.state = PAYLOAD;
          nxt.cnt   = '0;
          nxt.sum   = '0;
        end
      end
      PAYLOAD: begin
        if (bus.rx_update) begin
          for (int k = 0; k < LEN; k++) begin
            if (cur.cnt == CNT_W'(k)) begin
              nxt.data[k*8 +: 8] = bus.rx_data;
            end
          end
          nxt.sum = csum_total;
          nxt.cnt = cur.cnt + 1'b1;
          if (cur.cnt == CNT_W'(LEN - 1)) begin
            nxt.state = CSUM;
          end
        end else if (tmr_expire) begin
          nxt.state = IDLE;
          nxt.err   = 1'b1;
          nxt.code  = ERR_TIMEOUT;
        end
      end
      CSUM: begin
        if (bus.rx_update) begin
          if (csum_total == '0) begin
            nxt.state = HOLD;
            nxt.valid = 1'b1;
          end else begin
            nxt.state = IDLE;
            nxt.err   = 1'b1;
            nxt.code  = ERR_CSUM;
          end
        end else if (tmr_expire) begin
          nxt.state = IDLE;
          nxt.err   = 1'b1;
          nxt.code  = ERR_TIMEOUT;
        end
      end
      HOLD: begin
        // valid is always 1 here, so ready alone completes the handshake.
        // A byte arriving in the same cycle is treated as seen in IDLE.
        if (bus.frame_ready) begin
          nxt.state = IDLE;
          nxt.valid = 1'b0;
          if (bus.rx_update && (bus.rx_data == SYNC)) begin
            nxt.state = PAYLOAD;
            nxt.cnt   = '0;
            nxt.sum   = '0;
          end
        end else if (bus.rx_update) begin
          nxt.err  = 1'b1;
          nxt.code = ERR_OVERRUN;
        end
      end
      default: begin
        nxt.state = IDLE;
      end
    endcase
  end

  assign bus.frame_valid = cur.valid;
  assign bus.frame_data  = cur.data;
  assign bus.frame_err   = cur.err;
  assign bus.err_code    = cur.code;

endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  uart_frame_decoder_if #(.LEN(4)) bus ();

  uart_frame_decoder #(
    .SYNC    (8'hA5),
    .LEN     (4),
    .TIMEOUT (1000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          hs_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] hs_data = 32'h0;
  logic [1:0]  last_code = 2'd0;

  // Inputs change at posedge+3, so negedge sees what the next posedge will use.
  always @(negedge clk) begin
    if (bus.frame_valid && bus.frame_ready) begin
      hs_cnt++;
      hs_data = bus.frame_data;
    end
    if (bus.frame_err) begin
      err_cnt++;
      last_code = bus.err_code;
    end
  end

  task automatic strobe(input logic [7:0] b);
    @(posedge clk); #3;
    bus.rx_update = 1'b1;
    bus.rx_data   = b;
    @(posedge clk); #3;
    bus.rx_update = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe(b);
    repeat (8) @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] p);
    logic [7:0] s;
    s = p[7:0] + p[15:8] + p[23:16] + p[31:24];
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(p[i*8 +: 8]);
    send_byte(8'h00 - s);
  endtask

  task automatic test_reset;
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.frame_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", bus.frame_err); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", bus.err_code); end
    total++; if (bus.frame_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.frame_data); end
  endtask

  task automatic test_good_frame;
    int h0, e0;
    bus.frame_ready = 1'b1;
    h0 = hs_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL good_pre_valid got=%0b exp=0", bus.frame_valid); end
    strobe(8'hF6);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL good_latency got=%0b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 32'h04030201) begin bad++; $display("FAIL good_data got=%h exp=04030201", bus.frame_data); end
    repeat (8) @(posedge clk); #3;
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL good_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (hs_data !== 32'h04030201) begin bad++; $display("FAIL good_hs_data got=%h exp=04030201", hs_data); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL good_valid_drop got=%0b exp=0", bus.frame_valid); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL good_no_err got=%0d exp=%0d", err_cnt, e0); end
  endtask

  task automatic test_bad_csum;
    int h0, e0;
    bus.frame_ready = 1'b1;
    h0 = hs_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h00);
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL csum_err_pulses got=%0d exp=%0d", err_cnt, e0 + 1); end
    total++; if (last_code !== 2'd1) begin bad++; $display("FAIL csum_code got=%0d exp=1", last_code); end
    total++; if (bus.err_code !== 2'd1) begin bad++; $display("FAIL csum_code_held got=%0d exp=1", bus.err_code); end
    total++; if (hs_cnt !== h0) begin bad++; $display("FAIL csum_no_frame got=%0d exp=%0d", hs_cnt, h0); end
    send_frame(32'h44332211);
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL csum_recover got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (hs_data !== 32'h44332211) begin bad++; $display("FAIL csum_recover_data got=%h exp=44332211", hs_data); end
  endtask

  task automatic test_garbage;
    int h0;
    bus.frame_ready = 1'b1;
    h0 = hs_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF6);
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL garbage_count got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (hs_data !== 32'h04030201) begin bad++; $display("FAIL garbage_data got=%h exp=04030201", hs_data); end
    // SYNC inside the payload is plain data: 10 A5 20 30, checksum FB
    send_byte(8'hA5);
    send_byte(8'h10); send_byte(8'hA5); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'hFB);
    total++; if (hs_cnt !== h0 + 2) begin bad++; $display("FAIL sync_in_payload_count got=%0d exp=%0d", hs_cnt, h0 + 2); end
    total++; if (hs_data !== 32'h3020A510) begin bad++; $display("FAIL sync_in_payload_data got=%h exp=3020a510", hs_data); end
  endtask

  task automatic test_back_to_back;
    int h0, e0;
    bus.frame_ready = 1'b0;
    h0 = hs_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF6);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b exp=1", bus.frame_valid); end
    send_byte(8'h11);
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL bp_overrun_pulses got=%0d exp=%0d", err_cnt, e0 + 1); end
    total++; if (last_code !== 2'd2) begin bad++; $display("FAIL bp_overrun_code got=%0d exp=2", last_code); end
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_kept got=%0b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 32'h04030201) begin bad++; $display("FAIL bp_data_kept got=%h exp=04030201", bus.frame_data); end
    total++; if (hs_cnt !== h0) begin bad++; $display("FAIL bp_no_hs got=%0d exp=%0d", hs_cnt, h0); end
    @(posedge clk); #3;
    bus.rx_update   = 1'b1;
    bus.rx_data     = 8'hA5;
    bus.frame_ready = 1'b1;
    @(posedge clk); #3;
    bus.rx_update = 1'b0;
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL bp_simul_hs got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL bp_simul_valid got=%0b exp=0", bus.frame_valid); end
    repeat (8) @(posedge clk);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    send_byte(8'hE6);
    total++; if (hs_cnt !== h0 + 2) begin bad++; $display("FAIL bp_next_frame got=%0d exp=%0d", hs_cnt, h0 + 2); end
    total++; if (hs_data !== 32'h08070605) begin bad++; $display("FAIL bp_next_data got=%h exp=08070605", hs_data); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL bp_no_extra_err got=%0d exp=%0d", err_cnt, e0 + 1); end
  endtask

  task automatic test_timeout;
    int h0, e0;
    bus.frame_ready = 1'b1;
    h0 = hs_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (1000) @(posedge clk);
    #3;
`ifdef FRAME_TIMEOUT_EN
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=%0d", err_cnt, e0 + 1); end
    total++; if (last_code !== 2'd3) begin bad++; $display("FAIL timeout_code got=%0d exp=3", last_code); end
    send_frame(32'h0D0C0B0A);
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL timeout_recover got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (hs_data !== 32'h0D0C0B0A) begin bad++; $display("FAIL timeout_recover_data got=%h exp=0d0c0b0a", hs_data); end
`else
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL no_timeout_err got=%0d exp=%0d", err_cnt, e0); end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF6);
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL no_timeout_complete got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (hs_data !== 32'h04030201) begin bad++; $display("FAIL no_timeout_data got=%h exp=04030201", hs_data); end
`endif
  endtask

  task automatic test_reset_mid;
    int h0;
    bus.frame_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.frame_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_err got=%0b exp=0", bus.frame_err); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL rst_mid_code got=%0d exp=0", bus.err_code); end
    total++; if (bus.frame_data !== 32'h0) begin bad++; $display("FAIL rst_mid_data got=%h exp=0", bus.frame_data); end
    repeat (3) @(posedge clk); #3;
    reset_n = 1'b1;
    h0 = hs_cnt;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'hF6);
    total++; if (hs_cnt !== h0) begin bad++; $display("FAIL rst_mid_no_frame got=%0d exp=%0d", hs_cnt, h0); end
    send_frame(32'h04030201);
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL rst_mid_recover got=%0d exp=%0d", hs_cnt, h0 + 1); end
    total++; if (hs_data !== 32'h04030201) begin bad++; $display("FAIL rst_mid_recover_data got=%h exp=04030201", hs_data); end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.rx_update   = 1'b0;
    bus.rx_data     = 8'h00;
    bus.frame_ready = 1'b0;
    repeat (3) @(posedge clk); #3;
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    test_good_frame();
    test_bad_csum();
    test_garbage();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
